// File: rtl/log_reader_pkg.sv
// Shared types and constants for the log BlockRAM reader.
package log_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_MAX_WORDS = 32000;
    localparam int LOW_LATENCY       = 1;
    localparam int HIGH_PERFORMANCE  = 2;

endpackage

// File: rtl/log_reader_if.sv
// valid/ready word stream from the log reader toward the MicroBlaze/UART path.
interface log_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/log_reader_fifo.sv
// Small synchronous FIFO buffering RAM words ahead of the output stream.
module log_reader_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_wdata,
    input  logic                   i_pop,
    output logic [DATA_WIDTH-1:0]  o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    always_ff @(posedge clock) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    // Head reads as zero when empty so the stream data is clean out of reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/log_reader.sv
// Streams the first N words of the logging BlockRAM out over valid/ready,
// absorbing RAM read latency and consumer stalls in a small credit-managed FIFO.
module log_reader
    import log_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_WORDS   = DEFAULT_MAX_WORDS,
    parameter int RAM_LATENCY = LOW_LATENCY,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_num_words,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    log_reader_if.master          s_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_words_sent
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(MAX_WORDS);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_n;
    logic [ADDR_WIDTH-1:0]   r_issued;
    logic [ADDR_WIDTH-1:0]   r_words_sent;
    logic [RAM_LATENCY-1:0]  r_vld_pipe;
    logic                    r_done;

    logic [CW-1:0]           w_count;
    logic [CW-1:0]           w_inflight;
    logic                    w_empty, w_full;
    logic                    w_issue, w_accept, w_push, w_flush, w_last;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [ADDR_WIDTH-1:0]   w_n_clamped;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++)
            w_inflight = w_inflight + CW'(r_vld_pipe[i]);
    end

    // A read is only issued if its word is guaranteed a FIFO slot on arrival.
    assign w_issue  = (r_state == S_READ) && (r_issued < r_n) &&
                      ((w_count + w_inflight) < CW'(FIFO_DEPTH));
    assign w_push   = r_vld_pipe[RAM_LATENCY-1];
    assign w_accept = !w_empty && s_out.ready;
    assign w_flush  = i_abort && (r_state != S_IDLE);
    assign w_n_clamped = (i_num_words > MAX_N) ? MAX_N : i_num_words;

    // Looks ahead to the final handshake so o_done lands the cycle after it.
    assign w_last = (r_state == S_DRAIN) && (w_inflight == '0) &&
                    ((w_count == '0) || ((w_count == CW'(1)) && w_accept)) &&
                    ((r_words_sent + ADDR_WIDTH'(w_accept)) == r_n);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_issued     <= '0;
            r_words_sent <= '0;
            r_vld_pipe   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            for (int i = 1; i < RAM_LATENCY; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            if (w_accept) r_words_sent <= r_words_sent + ADDR_WIDTH'(1);
            r_done <= 1'b0;

            if (w_flush) begin
                r_state    <= S_IDLE;
                r_vld_pipe <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_start && !i_abort) begin
                        r_n          <= w_n_clamped;
                        r_issued     <= '0;
                        r_words_sent <= '0;
                        r_state      <= (w_n_clamped == '0) ? S_DONE : S_READ;
                    end
                    S_READ: if (w_issue) begin
                        r_issued <= r_issued + ADDR_WIDTH'(1);
                        if ((r_issued + ADDR_WIDTH'(1)) == r_n) r_state <= S_DRAIN;
                    end
                    S_DRAIN: if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                    // Empty dumps arrive here with r_done low and pulse one cycle later.
                    S_DONE: if (r_done) r_state <= S_IDLE;
                            else        r_done  <= 1'b1;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset && !w_flush) assert (!(w_push && w_full));
    end

    log_reader_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (i_rd_data),
        .i_pop   (w_accept),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign s_out.data   = w_head;
    assign s_out.valid  = !w_empty;
    assign o_rd_en      = w_issue;
    assign o_rd_addr    = w_issue ? r_issued : '0;
    assign o_busy       = (r_state == S_READ) || (r_state == S_DRAIN);
    assign o_done       = r_done;
    assign o_words_sent = r_words_sent;

endmodule

// File: doc/log_reader.md
Name: log_reader

Overview:
- Downstream consumer of the logging BlockRAM: after a capture, streams the first N logged 32-bit words out over a valid/ready interface toward the MicroBlaze/UART path.
- Drives the RAM read port (address, read enable), compensates the RAM read latency and buffers words in a small FIFO.
- A stalled consumer therefore never loses or duplicates a word.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 16, read address / word-count width.
- MAX_WORDS, 32000, logger depth; requested counts are clamped to this.
- RAM_LATENCY, 1, cycles from o_rd_en to valid i_rd_data (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).
- FIFO_DEPTH, 4, output buffer depth; must be >= RAM_LATENCY+1 and a power of 2.

Ports:
- clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse: begin dump; ignored unless IDLE
- i_abort  in  1  stop dump, flush, return to IDLE, no o_done
- i_num_words  in  ADDR_WIDTH  words to dump, sampled on accepted i_start
- o_rd_addr  out  ADDR_WIDTH  RAM read address
- o_rd_en  out  1  RAM read enable
- i_rd_data  in  DATA_WIDTH  RAM read data
- o_data  out  DATA_WIDTH  stream data
- o_valid  out  1  stream valid
- i_ready  in  1  stream ready
- o_busy  out  1  high in READ/DRAIN
- o_done  out  1  one-cycle pulse after the last word is accepted
- o_words_sent  out  ADDR_WIDTH  words accepted by consumer in current/last dump

Behaviour:
- Reset (clock and reset as already decided): state IDLE; o_rd_addr=0, o_rd_en=0, o_valid=0, o_data=0, o_busy=0, o_done=0, o_words_sent=0; FIFO and latency pipe cleared.
- Reset mid-dump discards in-flight reads.
- States:
  - IDLE: o_rd_en=0. On i_start, latch n = min(i_num_words, MAX_WORDS), clear issue counter and o_words_sent.
    - n=0: go to DONE.
    - n>0: go to READ.
  - READ: issue one read per cycle while issued<n and (fifo_count + inflight) < FIFO_DEPTH.
    - Issue means o_rd_en=1, o_rd_addr=issued, issued++.
    - When issued==n, go to DRAIN.
  - DRAIN: o_rd_en=0; wait until inflight=0, FIFO empty and o_words_sent==n, then go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE. o_words_sent holds until the next start.
- Latency pipe: shift register of o_rd_en, RAM_LATENCY stages. When its last stage is high, i_rd_data is written to the FIFO in that cycle. inflight = popcount of the pipe.
- Credit rule guarantees the FIFO never overflows; a write into a full FIFO is a design error and is flagged by an assertion.
- Timing, i_start in cycle 0, consumer always ready:
  - First o_rd_en in cycle 1.
  - First o_valid in cycle 2+RAM_LATENCY.
  - Then one word per cycle.
  - o_done is 1 cycle after the last handshake.
- Stream: o_data/o_valid come from the FIFO head. A word is accepted when o_valid & i_ready, which increments o_words_sent.
- o_valid, once high, stays high with o_data stable until accepted.
- Simultaneous FIFO write and read on the same cycle: count unchanged, both happen.
- i_abort in any non-IDLE state: next cycle IDLE, o_rd_en=0, FIFO and pipe flushed, o_done not pulsed, o_words_sent keeps the accepted count.
- i_abort has priority over i_start.
- i_start while busy: ignored.
- Addresses never exceed n-1; no wrap-around. Counters are ADDR_WIDTH wide and MAX_WORDS < 2^ADDR_WIDTH.

Decomposition:
- Shared package/header: state encodings (IDLE, READ, DRAIN, DONE), default MAX_WORDS, RAM latency constants matching LOW_LATENCY/HIGH_PERFORMANCE.
- One sub-module: log_reader_fifo, a synchronous FIFO (DATA_WIDTH, FIFO_DEPTH) with push, pop, count, full, empty, flush.
- Control FSM, credit logic and latency pipe stay in log_reader.

Test Plan:
- RAM model preloaded with word[k]=k+0x100; i_start, i_num_words=8, i_ready=1 -> o_rd_addr 0..7 on cycles 1..8; o_data 0x100..0x107 on cycles 3..10; o_done cycle 11; o_words_sent=8.
- Same dump with i_ready toggling 1/0 each cycle, then held low 10 cycles -> no lost or duplicated word; at most 4 reads outstanding+buffered; o_data stable while stalled.
- i_num_words=0 -> no o_rd_en, no o_valid, o_done 2 cycles after i_start; i_num_words=40000 -> exactly 32000 words, last address 31999.
- i_abort after 5 accepted words of a 100-word dump -> IDLE next cycle, o_valid=0, no o_done, o_words_sent=5; new i_start then restarts at address 0.
- i_reset asserted mid-READ with reads in flight -> all outputs at reset values next cycle; stale i_rd_data not emitted after reset release.
- RAM_LATENCY=2, FIFO_DEPTH=4, 16 words, random i_ready -> data order correct; first o_valid at cycle 4.
